// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-granular memory port between the I-cache miss
//   path and the D-cache miss/writeback path; round-robin on simultaneous requests.
// Latency: a request seen in IDLE drives the memory command the next cycle; the
//   client resp is combinational with pmem_resp. At least one IDLE cycle sits
//   between transactions.
// Backpressure: clients hold their request until their resp pulse. The granted
//   request is latched, so later client input changes are ignored until completion.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_pmem_*               I-cache side (read only)
//   d_pmem_*               D-cache side (read or writeback)
//   pmem_*                 physical memory port

module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_d;   // 1: last grant went to D, 0: to I
  logic                r_read;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;

  logic w_req_i;
  logic w_req_d;
  logic w_grant_d;

  assign w_req_i   = i_pmem_read;
  assign w_req_d   = d_pmem_read | d_pmem_write;
  // On a tie, serve whichever side did not get the previous grant.
  assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A pmem_resp seen here is stale and deliberately ignored.
          if (w_req_i | w_req_d) begin
            r_last_d <= w_grant_d;
            if (w_grant_d) begin
              r_state <= SERVE_D;
              r_addr  <= d_pmem_address;
              // Read and write together is treated as a writeback.
              r_write <= d_pmem_write;
              r_read  <= ~d_pmem_write;
              r_wdata <= d_pmem_write ? d_pmem_wdata : '0;
            end else begin
              r_state <= SERVE_I;
              r_addr  <= i_pmem_address;
              r_write <= 1'b0;
              r_read  <= 1'b1;
              r_wdata <= '0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // Memory side comes only from latched state: no path from client inputs.
  assign pmem_read    = r_read;
  assign pmem_write   = r_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Data fans out to both clients; only the strobes are steered.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (r_state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level reference: is a memory op outstanding, for whom, and what.
  bit            m_busy = 1'b0;
  bit            m_side = 1'b0;   // 0 = I, 1 = D
  bit            m_last = 1'b0;   // side of the previous grant
  bit            m_wr   = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;
  int            grants[$];
  int            cnt_i = 0;
  int            cnt_d = 0;
  bit            chk_en = 1'b0;
  bit            auto_i = 1'b1;
  bit            auto_d = 1'b1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, predict the next transaction state from
  // the arbitration rules, then let client models drop requests once answered.
  task automatic step();
    bit            n_busy, n_side, n_last, n_wr, rq_i, rq_d, saw_i, saw_d, g_d;
    logic [AW-1:0] n_addr;
    logic [LW-1:0] n_wdata;
    @(negedge clk);
    saw_i = i_pmem_resp;
    saw_d = d_pmem_resp;
    if (chk_en) begin
      check1("pmem_read",  pmem_read,  m_busy && !m_wr);
      check1("pmem_write", pmem_write, m_busy && m_wr);
      if (m_busy) begin
        checkw("pmem_address", LW'(pmem_address), LW'(m_addr));
        checkw("pmem_wdata",   pmem_wdata,        m_wr ? m_wdata : '0);
      end
      check1("i_pmem_resp", i_pmem_resp, m_busy && !m_side && pmem_resp);
      check1("d_pmem_resp", d_pmem_resp, m_busy && m_side && pmem_resp);
      checkw("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
      checkw("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    end
    if (saw_i) cnt_i++;
    if (saw_d) cnt_d++;
    n_busy = m_busy; n_side = m_side; n_last = m_last;
    n_wr = m_wr; n_addr = m_addr; n_wdata = m_wdata;
    rq_i = i_pmem_read;
    rq_d = d_pmem_read | d_pmem_write;
    if (rst) begin
      n_busy = 0; n_last = 0; n_wr = 0; n_addr = '0; n_wdata = '0;
    end else if (m_busy) begin
      if (pmem_resp) n_busy = 0;
    end else if (rq_i || rq_d) begin
      g_d    = rq_d && (!rq_i || !m_last);
      n_busy = 1; n_side = g_d; n_last = g_d;
      n_addr = g_d ? d_pmem_address : i_pmem_address;
      n_wr   = g_d && d_pmem_write;
      n_wdata = n_wr ? d_pmem_wdata : '0;
      grants.push_back(int'(g_d));
    end
    @(posedge clk);
    m_busy = n_busy; m_side = n_side; m_last = n_last;
    m_wr = n_wr; m_addr = n_addr; m_wdata = n_wdata;
    #1;
    if (saw_i && auto_i) i_pmem_read = 1'b0;
    if (saw_d && auto_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
  endtask

  task automatic do_reset();
    rst = 1'b1; pmem_resp = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Memory answers after `lat` quiet cycles.
  task automatic mem_respond(input int lat);
    pmem_resp = 1'b0;
    for (int k = 0; k < lat; k++) step();
    pmem_rdata = {8{$urandom}};
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
  endtask

  // Free-running memory that answers randomly (also pulses resp while idle).
  task automatic run_random_mem(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      pmem_rdata = {8{$urandom}};
      pmem_resp  = ($urandom_range(0, 2) == 0);
      step();
    end
    pmem_resp = 1'b0;
  endtask

  logic [LW-1:0] pat_a5;
  int            c0;

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    pat_a5 = {32{8'hA5}};
    @(posedge clk); #1;
    do_reset();
    chk_en = 1'b1;
    check1("rst_read",  pmem_read,  1'b0);
    check1("rst_write", pmem_write, 1'b0);
    checkw("rst_addr",  LW'(pmem_address), '0);
    checkw("rst_wdata", pmem_wdata, '0);

    // Single I miss, memory answers 3 cycles after the command.
    i_pmem_read = 1; i_pmem_address = 32'h0000_1A40;
    c0 = cnt_d;
    step();
    check1("imiss_cmd", pmem_read, 1'b1);
    checkw("imiss_addr", LW'(pmem_address), LW'(32'h0000_1A40));
    mem_respond(2);
    step(); step();
    checkw("imiss_resp_cnt", LW'(cnt_i), LW'(1));
    checkw("imiss_no_dresp", LW'(cnt_d), LW'(c0));

    // D writeback; client scrubs its wdata while the op is outstanding.
    d_pmem_write = 1; d_pmem_address = 32'h8000_0100; d_pmem_wdata = pat_a5;
    c0 = cnt_d;
    step();
    d_pmem_wdata = '0;
    step();
    check1("wb_cmd", pmem_write, 1'b1);
    checkw("wb_wdata_held", pmem_wdata, pat_a5);
    mem_respond(1);
    step();
    checkw("wb_resp_cnt", LW'(cnt_d - c0), LW'(1));

    // Read+write together at 0x40 is a writeback.
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h40; d_pmem_wdata = {8{$urandom}};
    step();
    check1("rw_write", pmem_write, 1'b1);
    check1("rw_read",  pmem_read,  1'b0);
    mem_respond(2);
    step();

    // Reset while serving D: the late pmem_resp must not reach the client.
    do_reset();
    d_pmem_write = 1; d_pmem_address = 32'h1234_5600; d_pmem_wdata = {8{$urandom}};
    c0 = cnt_d;
    step(); step();
    check1("abort_busy", pmem_write, 1'b1);
    rst = 1; d_pmem_write = 0;
    step();
    rst = 0; pmem_resp = 1;
    check1("abort_wr0", pmem_write, 1'b0);
    step();
    pmem_resp = 0;
    step();
    checkw("abort_no_resp", LW'(cnt_d - c0), LW'(0));

    // Tie after reset goes to D, then I.
    do_reset();
    grants.delete();
    i_pmem_read = 1; i_pmem_address = 32'hAAAA_0000;
    d_pmem_read = 1; d_pmem_address = 32'hDDDD_0000;
    run_random_mem(40);
    checkw("tie_ngrants", LW'(grants.size()), LW'(2));
    if (grants.size() >= 2) begin
      checkw("tie_first_D",  LW'(grants[0]), LW'(1));
      checkw("tie_second_I", LW'(grants[1]), LW'(0));
    end

    // Both sides hold requests continuously: grants alternate D, I, D, I ...
    do_reset();
    grants.delete();
    auto_i = 0; auto_d = 0;
    i_pmem_read = 1; d_pmem_read = 1;
    run_random_mem(120);
    i_pmem_read = 0; d_pmem_read = 0;
    auto_i = 1; auto_d = 1;
    run_random_mem(20);
    check1("alt_enough", grants.size() >= 6, 1'b1);
    for (int k = 0; k < grants.size() && k < 10; k++)
      checkw("alt_order", LW'(grants[k]), LW'((k % 2 == 0) ? 1 : 0));

    // Randomized clients, including request drops and address churn while waiting.
    for (int k = 0; k < 3000; k++) begin
      if (!i_pmem_read && $urandom_range(0, 3) == 0) begin
        i_pmem_read = 1; i_pmem_address = $urandom;
      end else if (i_pmem_read && $urandom_range(0, 15) == 0) begin
        i_pmem_address = $urandom;
      end else if (i_pmem_read && $urandom_range(0, 31) == 0) begin
        i_pmem_read = 0;
      end
      if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 3) == 0) begin
        d_pmem_read = 1'($urandom); d_pmem_write = 1'($urandom);
        if (!d_pmem_read && !d_pmem_write) d_pmem_read = 1;
        d_pmem_address = $urandom; d_pmem_wdata = {8{$urandom}};
      end else if ((d_pmem_read || d_pmem_write) && $urandom_range(0, 15) == 0) begin
        d_pmem_wdata = {8{$urandom}}; d_pmem_address = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      pmem_rdata = {8{$urandom}};
      pmem_resp  = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
